// File: rtl/regfile.sv
// regfile: architectural register file with a per-register pending-write
// scoreboard. Receives writeback data and scoreboard releases, serves two
// registered read ports with busy flags, and accepts destination locks.
module regfile #(
    parameter int LOG_REG_CNT = 5,
    parameter int REG_LEN     = 32,
    parameter int PEND_W      = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rdy,
    input  logic                   write_reg,
    input  logic [LOG_REG_CNT-1:0] reg_id,
    input  logic [REG_LEN-1:0]     reg_val,
    input  logic                   write_reg_stall,
    input  logic [LOG_REG_CNT-1:0] reg_stall_id,
    input  logic                   read1_en,
    input  logic [LOG_REG_CNT-1:0] read1_id,
    input  logic                   read2_en,
    input  logic [LOG_REG_CNT-1:0] read2_id,
    output logic [REG_LEN-1:0]     read1_val,
    output logic [REG_LEN-1:0]     read2_val,
    output logic                   read1_busy,
    output logic                   read2_busy,
    input  logic                   lock_en,
    input  logic [LOG_REG_CNT-1:0] lock_id,
    output logic                   lock_ok,
    output logic                   underflow
);

    localparam int                     REG_CNT  = 1 << LOG_REG_CNT;
    localparam logic [PEND_W-1:0]      PEND_MAX = '1;
    localparam logic [LOG_REG_CNT-1:0] ZERO_ID  = '0;

    logic [REG_LEN-1:0] regs [REG_CNT];
    logic [PEND_W-1:0]  pend [REG_CNT];

    logic               rel_vld;
    logic               lock_vld;
    logic               rel_lock_same;
    logic [REG_LEN-1:0] rd1_val_nxt;
    logic [REG_LEN-1:0] rd2_val_nxt;
    logic               rd1_busy_nxt;
    logic               rd2_busy_nxt;

    // Count seen by a reader: this cycle's release applied, this cycle's lock not.
    function automatic logic [PEND_W-1:0] pend_after_rel(input logic [PEND_W-1:0] p,
                                                         input logic hit);
        pend_after_rel = (hit && p != '0) ? p - 1'b1 : p;
    endfunction

    // Release/lock qualification; a same-id release frees the slot for the lock.
    always_comb begin
        rel_vld       = write_reg_stall && (reg_stall_id != ZERO_ID);
        lock_ok       = (lock_id == ZERO_ID) || (pend[lock_id] != PEND_MAX) ||
                        (rel_vld && (reg_stall_id == lock_id));
        lock_vld      = lock_en && (lock_id != ZERO_ID) && lock_ok;
        rel_lock_same = rel_vld && lock_vld && (reg_stall_id == lock_id);
    end

    // Next read data/busy for both ports, with write-through bypass.
    always_comb begin
        rd1_val_nxt = regs[read1_id];
        if (read1_id == ZERO_ID)
            rd1_val_nxt = '0;
        else if (write_reg && (reg_id == read1_id))
            rd1_val_nxt = reg_val;

        rd2_val_nxt = regs[read2_id];
        if (read2_id == ZERO_ID)
            rd2_val_nxt = '0;
        else if (write_reg && (reg_id == read2_id))
            rd2_val_nxt = reg_val;

        rd1_busy_nxt = read1_en && (read1_id != ZERO_ID) &&
                       (pend_after_rel(pend[read1_id],
                                       rel_vld && (reg_stall_id == read1_id)) != '0);
        rd2_busy_nxt = read2_en && (read2_id != ZERO_ID) &&
                       (pend_after_rel(pend[read2_id],
                                       rel_vld && (reg_stall_id == read2_id)) != '0);
    end

    // Register storage: writeback into nonzero destinations.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_CNT; i++)
                regs[i] <= '0;
        end else if (rdy && write_reg && (reg_id != ZERO_ID)) begin
            regs[reg_id] <= reg_val;
        end
    end

    // Scoreboard counters and sticky underflow; same-id lock+release nets to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_CNT; i++)
                pend[i] <= '0;
            underflow <= 1'b0;
        end else if (rdy) begin
            if (rel_vld && (pend[reg_stall_id] == '0))
                underflow <= 1'b1;
            if (!rel_lock_same) begin
                if (rel_vld && (pend[reg_stall_id] != '0))
                    pend[reg_stall_id] <= pend[reg_stall_id] - 1'b1;
                if (lock_vld)
                    pend[lock_id] <= pend[lock_id] + 1'b1;
            end
        end
    end

    // Registered read ports; hold while rdy is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read1_val  <= '0;
            read2_val  <= '0;
            read1_busy <= 1'b0;
            read2_busy <= 1'b0;
        end else if (rdy) begin
            read1_val  <= rd1_val_nxt;
            read2_val  <= rd2_val_nxt;
            read1_busy <= rd1_busy_nxt;
            read2_busy <= rd2_busy_nxt;
        end
    end

endmodule

// File: doc/regfile.md
# regfile

Architectural register file with per-register pending-write scoreboard. It is the receiving end of the writeback stage. It accepts writeback data (`write_reg`/`reg_id`/`reg_val`) and scoreboard releases (`write_reg_stall`/`reg_stall_id`). It serves two registered read ports and busy flags to decode, and accepts destination locks from issue.

## Interface
- `LOG_REG_CNT`, default 5: register index width; there are 2^LOG_REG_CNT registers.
- `REG_LEN`, default 32: register data width.
- `PEND_W`, default 2: pending-write counter width per register; the maximum count is 2^PEND_W-1.

Ports:
- `clk`  in  1  clock. This is the only clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `rdy`  in  1  global enable. When low, all state and outputs hold.
- `write_reg`  in  1  writeback data valid.
- `reg_id`  in  LOG_REG_CNT  writeback destination.
- `reg_val`  in  REG_LEN  writeback data.
- `write_reg_stall`  in  1  scoreboard release valid.
- `reg_stall_id`  in  LOG_REG_CNT  register to release.
- `read1_en`, `read2_en`  in  1  read port enables.
- `read1_id`, `read2_id`  in  LOG_REG_CNT  read indices.
- `read1_val`, `read2_val`  out  REG_LEN  registered read data.
- `read1_busy`, `read2_busy`  out  1  registered; the source has an outstanding write.
- `lock_en`  in  1  issue locks a destination this cycle.
- `lock_id`  in  LOG_REG_CNT  destination to lock.
- `lock_ok`  out  1  combinational; the lock will be accepted.
- `underflow`  out  1  sticky error; set when a release hits a zero counter.

## Operation
- Storage: `regs[0..2^LOG_REG_CNT-1]` of REG_LEN bits, and `pend[]` of PEND_W bits each.
- Register 0 always reads 0 and is never busy. Writes, locks and releases to id 0 are ignored with no error.
- Write: on a clock edge where `rdy` is high, `write_reg` is high and `reg_id` is nonzero, `regs[reg_id] <= reg_val`.
- Release: when `write_reg_stall` is high and `reg_stall_id` is nonzero:
  - if `pend[id]` is greater than 0, it decrements;
  - if `pend[id]` is 0, it stays 0 and `underflow` is set to 1 until reset.
- Lock: when `lock_en` is high, `lock_id` is nonzero and `lock_ok` is high, `pend[lock_id]` increments.
  - `lock_ok` = (`lock_id` == 0) or (`pend[lock_id]` < max), or a release of the same id occurs in the same cycle.
  - When `lock_ok` is low the lock is dropped. Issue must not lock when `lock_ok` is low.
- Lock and release of the same id in the same cycle: the net `pend` change is 0.
- Reads, port n, updated on each enabled edge:
  - `readn_val` <= 0 if `readn_id` is 0.
  - Otherwise `readn_val` <= `reg_val` if `write_reg` is high and `reg_id` == `readn_id` (write-through bypass).
  - Otherwise `readn_val` <= `regs[readn_id]`.
  - `readn_busy` <= `readn_en` and (`readn_id` != 0) and (`pend_after_release[readn_id]` != 0). `pend_after_release` applies this cycle's release but not this cycle's lock, so an instruction never sees its own destination lock.
  - When `readn_en` is low, `readn_val` still updates and `readn_busy` is 0.
- Arithmetic on `pend` is unsigned PEND_W bits. It never wraps: increments are gated by `lock_ok` and decrements by the nonzero check.

## Timing
- Reset, asynchronous: all `regs` are 0, all `pend` are 0, `read1_val`/`read2_val` are 0, `read1_busy`/`read2_busy` are 0, and `underflow` is 0.
  - `lock_ok` follows the combinational rule from reset state, so it is 1.
  - Reset asserted mid-operation discards all pending counts and data on the assertion edge, not the next clock.
- Read latency: 1 cycle. The indices presented at edge k produce data and busy valid after edge k.
- Writeback-to-read: a write at edge k is visible to a read issued at the same edge k through the bypass.
- Release-to-busy-clear: a release at edge k makes a same-edge read of that id report not busy, provided the count reaches 0.
- Lock-to-busy: a lock at edge k makes reads at edge k+1 onward report busy.
- `rdy` low: writes, locks, releases and `underflow` updates are all suppressed. Read outputs hold their previous values.
- There are no internal multi-cycle states. The sequential state is `regs`, `pend`, the read output registers and `underflow`.

## Test plan
- Reset, then read x0..x31 on both ports: all `val` = 0 and `busy` = 0. `lock_ok` = 1 and `underflow` = 0.
- Write x5 = 0xDEADBEEF at edge k while reading x5 at edge k: `read1_val` = 0xDEADBEEF after edge k. A later read of x5 also returns it. Writing x0 = 0x1234 leaves x0 reading 0.
- Lock x7 three times with PEND_W = 2:
  - after the locks, `lock_ok` = 0 for x7;
  - a fourth lock is dropped;
  - three releases are needed before `read2_busy` for x7 returns 0;
  - a fourth release sets `underflow` = 1.
- Same-cycle events:
  - Lock and release of x9 in one cycle with `pend` = 1: `pend` stays 1 and the read remains busy.
  - Lock x3 while reading x3 in the same cycle with `pend` = 0: `busy` = 0 that cycle and 1 on the next read.
- Hold `rdy` = 0 while driving a write of x4 = 0x55, a lock of x4, and reads of x4: nothing changes and the outputs hold. After `rdy` returns to 1, x4 reads 0.
- Assert `rst` asynchronously between edges after writing x2 = 0xA5 and locking x2: the outputs go to 0 immediately. After reset, x2 reads 0 and is not busy.
